ibm1620_mem_cycle_ctl: RTL and testbench

Core-memory cycle controller for the 1620 clock section. It sequences one memory cycle as a walk through clock ring positions C1..C10, paced by the clock-drive advance pulse, and decodes read-drive, sense-strobe and write-drive timing from the ring. It also arbitrates core access between the CPU (A/B field fetches) and an I/O cycle-steal requester. It sits between the oscillator/clock-drive logic and the core array drivers, and replaces ad-hoc ring gating with one sequenced owner.

---
 rtl/ibm1620_mem_cycle_ctl.sv | 196 +++++++++++++++++++
 tb/tb_ibm1620_mem_cycle_ctl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibm1620_mem_cycle_ctl.sv
//------------------------------------------------------------------------------
// ibm1620_mem_cycle_ctl
//
// Core-memory cycle controller for the 1620 clock section. One memory cycle is
// a walk of a one-hot clock ring through positions C1..C(RING_LEN). Each
// clock-drive advance pulse (i_adv) steps the ring once. The read-drive,
// sense-strobe and write-drive timing signals are decoded from the ring.
// The block also decides whether the CPU or the I/O cycle-steal requester
// owns each cycle.
//
// Optional feature macro: CYCLE_STEAL_EN
//   defined   : I/O requests are served with priority over the CPU.
//   undefined : i_io_req is ignored; o_grant_io and o_io_done are tied 0.
//
// Parameters
//   RING_LEN     ring positions per memory cycle (legal 6..16)
//   READ_END     last position (1-based) with read drive active
//   WRITE_START  first position with write drive active (ends at RING_LEN-1)
//
// Ports
//   i_sysclock      system clock, all state on the rising edge
//   i_reset_n       asynchronous active-low reset
//   i_adv           clock-drive advance pulse, steps the ring once per high clock
//   i_cpu_req       CPU memory-cycle request (level)
//   i_io_req        I/O cycle-steal request (level)
//   i_stop          halt request, honoured only at a cycle boundary
//   o_ring          one-hot ring position (bit 0 = C1), zero when idle
//   o_grant_cpu     CPU owns the current cycle
//   o_grant_io      I/O owns the current cycle
//   o_read_drive    high for positions 1..READ_END
//   o_sense_strobe  one-clock pulse after the step that enters READ_END
//   o_write_drive   high for positions WRITE_START..RING_LEN-1
//   o_cpu_done      one-clock pulse when a CPU cycle completes
//   o_io_done       one-clock pulse when an I/O cycle completes
//   o_ab_sel        A/B field trigger (0 = A-cycle, 1 = B-cycle)
//   o_busy          high whenever the ring is non-zero
//------------------------------------------------------------------------------
module ibm1620_mem_cycle_ctl #(
   parameter int RING_LEN    = 10,
   parameter int READ_END    = 3,
   parameter int WRITE_START = 6
) (
   input  logic                i_sysclock,
   input  logic                i_reset_n,
   input  logic                i_adv,
   input  logic                i_cpu_req,
   input  logic                i_io_req,
   input  logic                i_stop,
   output logic [RING_LEN-1:0] o_ring,
   output logic                o_grant_cpu,
   output logic                o_grant_io,
   output logic                o_read_drive,
   output logic                o_sense_strobe,
   output logic                o_write_drive,
   output logic                o_cpu_done,
   output logic                o_io_done,
   output logic                o_ab_sel,
   output logic                o_busy
);

   // Bit mask of the ring positions lo..hi (1-based, inclusive).
   function automatic logic [RING_LEN-1:0] f_window(input int lo, input int hi);
      logic [RING_LEN-1:0] m;
      m = '0;
      for (int i = 0; i < RING_LEN; i++) begin
         if ((i + 1 >= lo) && (i + 1 <= hi)) m[i] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [RING_LEN-1:0] RING_C1    = {{(RING_LEN-1){1'b0}}, 1'b1};
   localparam logic [RING_LEN-1:0] READ_MASK  = f_window(1, READ_END);
   localparam logic [RING_LEN-1:0] WRITE_MASK = f_window(WRITE_START, RING_LEN - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   logic [RING_LEN-1:0] r_ring;
   logic                r_grant_cpu;
   logic                r_grant_io;
   logic                r_read_drive;
   logic                r_sense_strobe;
   logic                r_write_drive;
   logic                r_cpu_done;
   logic                r_io_done;
   logic                r_ab_sel;
   logic                r_busy;

   logic                w_io_req;
   logic                w_req_any;
   logic                w_at_last;
   logic                w_end;
   logic                w_start;
   logic                w_step;
   logic [RING_LEN-1:0] w_ring_nxt;

`ifdef CYCLE_STEAL_EN
   assign w_io_req = i_io_req;
`else
   assign w_io_req = 1'b0;
`endif

   assign w_req_any = w_io_req | i_cpu_req;
   assign w_at_last = r_ring[RING_LEN-1];

   // The advance taken while sitting at the last position closes the cycle.
   assign w_end  = (r_state == ST_RUN) & i_adv & w_at_last;
   // Ordinary mid-cycle step.
   assign w_step = (r_state == ST_RUN) & i_adv & ~w_at_last;
   // A new cycle may open from idle or directly on the closing advance, so
   // back-to-back cycles have no idle gap. STOP only blocks openings.
   assign w_start = i_adv & ~i_stop & w_req_any &
                    ((r_state == ST_IDLE) | w_end);

   always_comb begin
      w_ring_nxt = r_ring;
      if (w_start) begin
         w_ring_nxt = RING_C1;
      end else if (w_end) begin
         w_ring_nxt = '0;
      end else if (w_step) begin
         w_ring_nxt = {r_ring[RING_LEN-2:0], 1'b0};
      end
   end

   // Sequencer: ring, ownership and all timing outputs are registered together
   // from the next ring value so they switch on the same clock edge.
   always_ff @(posedge i_sysclock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state        <= ST_IDLE;
         r_ring         <= '0;
         r_grant_cpu    <= 1'b0;
         r_grant_io     <= 1'b0;
         r_read_drive   <= 1'b0;
         r_sense_strobe <= 1'b0;
         r_write_drive  <= 1'b0;
         r_cpu_done     <= 1'b0;
         r_io_done      <= 1'b0;
         r_ab_sel       <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_ring        <= w_ring_nxt;
         r_read_drive  <= |(w_ring_nxt & READ_MASK);
         r_write_drive <= |(w_ring_nxt & WRITE_MASK);
         r_busy        <= |w_ring_nxt;
         // Strobe only on entry, so a stalled ring does not re-fire it.
         r_sense_strobe <= w_ring_nxt[READ_END-1] & ~r_ring[READ_END-1];

         r_cpu_done <= w_end & r_grant_cpu;
         r_io_done  <= w_end & r_grant_io;
         if (w_end && r_grant_cpu) begin
            r_ab_sel <= ~r_ab_sel;
         end

         // Ownership is decided only when a cycle opens and is held to the
         // end: a destructive read must always be followed by its restore.
         if (w_start) begin
            r_grant_io  <= w_io_req;
            r_grant_cpu <= ~w_io_req;
         end else if (w_end) begin
            r_grant_io  <= 1'b0;
            r_grant_cpu <= 1'b0;
         end

         case (r_state)
            ST_IDLE: if (w_start) r_state <= ST_RUN;
            ST_RUN:  if (w_end && !w_start) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_ring         = r_ring;
   assign o_grant_cpu    = r_grant_cpu;
   assign o_read_drive   = r_read_drive;
   assign o_sense_strobe = r_sense_strobe;
   assign o_write_drive  = r_write_drive;
   assign o_cpu_done     = r_cpu_done;
   assign o_ab_sel       = r_ab_sel;
   assign o_busy         = r_busy;

`ifdef CYCLE_STEAL_EN
   assign o_grant_io = r_grant_io;
   assign o_io_done  = r_io_done;
`else
   // Cycle steal is not built: the I/O side is held inactive.
   logic [1:0] w_unused_io;
   assign w_unused_io = {i_io_req, r_io_done};
   assign o_grant_io  = 1'b0;
   assign o_io_done   = 1'b0;
`endif

endmodule

// File: tb/tb_ibm1620_mem_cycle_ctl.sv
module tb_ibm1620_mem_cycle_ctl;
   localparam int RL = 10;
   localparam int RE = 3;
   localparam int WS = 6;
   localparam int VW = RL + 9;
`ifdef CYCLE_STEAL_EN
   localparam bit STEAL = 1'b1;
`else
   localparam bit STEAL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic adv = 1'b0, cpu = 1'b0, io = 1'b0, stop = 1'b0;
   logic [RL-1:0] ring;
   logic gcpu, gio, rd, ss, wd, cd, id, ab, busy;

   always #5 clk = ~clk;

   ibm1620_mem_cycle_ctl #(.RING_LEN(RL), .READ_END(RE), .WRITE_START(WS)) dut (
      .i_sysclock(clk), .i_reset_n(rst_n), .i_adv(adv), .i_cpu_req(cpu),
      .i_io_req(io), .i_stop(stop), .o_ring(ring), .o_grant_cpu(gcpu),
      .o_grant_io(gio), .o_read_drive(rd), .o_sense_strobe(ss),
      .o_write_drive(wd), .o_cpu_done(cd), .o_io_done(id), .o_ab_sel(ab),
      .o_busy(busy)
   );

   wire [VW-1:0] obs = {ring, gcpu, gio, rd, ss, wd, cd, id, ab, busy};

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: integer ring position (0 = idle), owner, A/B flag.
   int m_pos = 0;    // 0 idle, 1..RL
   int m_owner = 0;  // 0 none, 1 cpu, 2 io
   bit m_ab = 0, m_sense = 0, m_cdone = 0, m_idone = 0;

   task automatic model_reset();
      m_pos = 0; m_owner = 0; m_ab = 0; m_sense = 0; m_cdone = 0; m_idone = 0;
   endtask

   task automatic model_step(input bit a, input bit c, input bit i, input bit s);
      bit io_e;
      io_e = STEAL & i;
      m_sense = 0; m_cdone = 0; m_idone = 0;
      if (a) begin
         if (m_pos == RL) begin
            if (m_owner == 1) begin m_cdone = 1; m_ab = ~m_ab; end
            else m_idone = 1;
            m_pos = 0; m_owner = 0;
         end else if (m_pos != 0) begin
            m_pos++;
            if (m_pos == RE) m_sense = 1;
         end
         if (m_pos == 0 && !s && (io_e || c)) begin
            m_owner = io_e ? 2 : 1;
            m_pos = 1;
            if (RE == 1) m_sense = 1;
         end
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [RL-1:0] er;
      er = '0;
      if (m_pos != 0) er[m_pos-1] = 1'b1;
      return {er, (m_owner == 1), (m_owner == 2), (m_pos >= 1 && m_pos <= RE),
              m_sense, (m_pos >= WS && m_pos <= RL - 1), m_cdone, m_idone,
              m_ab, (m_pos != 0)};
   endfunction

   // Apply one clock of stimulus and leave time 1 unit after the rising edge.
   task automatic drive_step(input bit a, input bit c, input bit i, input bit s);
      adv = a; cpu = c; io = i; stop = s;
      model_step(a, c, i, s);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      adv = 0; cpu = 0; io = 0; stop = 0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", obs, exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      do_reset();
      for (int k = 0; k < 60; k++) begin
         drive_step((k % 3) == 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         n_checks++;
         if (obs !== exp_vec() || obs !== '0) begin
            n_fail++;
            $display("FAIL idle k=%0d: got %h expected %h", k, obs, exp_vec());
         end
      end
   endtask

   task automatic test_single_cpu();
      int dones = 0, strobes = 0;
      do_reset();
      for (int k = 0; k < 14 * 3; k++) begin
         // request dropped mid-cycle: the cycle must still complete
         drive_step((k % 3) == 0, (k / 3) < 5, 1'b0, 1'b0);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_cpu k=%0d: got %h expected %h", k, obs, exp_vec());
         end
         if (k == 0) begin
            n_checks++;
            if (gcpu !== 1'b1 || ring !== 10'd1) begin
               n_fail++;
               $display("FAIL single_grant: got gcpu=%b ring=%h expected 1 001", gcpu, ring);
            end
         end
         dones += int'(cd);
         strobes += int'(ss);
      end
      n_checks++;
      if (dones != 1 || strobes != 1 || ab !== 1'b1) begin
         n_fail++;
         $display("FAIL single_summary: got dones=%0d strobes=%0d ab=%b expected 1 1 1",
                  dones, strobes, ab);
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      logic [2:0] abseq = '0;
      do_reset();
      for (int j = 1; j <= 31; j++) begin
         for (int p = 0; p < 2; p++) begin
            drive_step(p == 0, j <= 21, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL b2b j=%0d p=%0d: got %h expected %h", j, p, obs, exp_vec());
            end
            if (cd === 1'b1) begin
               abseq = {abseq[1:0], ab};
               dones++;
               if (j < 31) begin
                  n_checks++;
                  if (gcpu !== 1'b1 || ring !== 10'd1) begin
                     n_fail++;
                     $display("FAIL b2b_nogap j=%0d: got gcpu=%b ring=%h expected 1 001",
                              j, gcpu, ring);
                  end
               end
            end
         end
      end
      n_checks++;
      if (dones != 3 || abseq !== 3'b101 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_summary: got dones=%0d abseq=%b busy=%b expected 3 101 0",
                  dones, abseq, busy);
      end
   endtask

   task automatic test_cycle_steal();
      do_reset();
`ifdef CYCLE_STEAL_EN
      for (int j = 1; j <= 21; j++) begin
         for (int p = 0; p < 2; p++) begin
            drive_step(p == 0, j <= 11, j <= 1, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL steal j=%0d p=%0d: got %h expected %h", j, p, obs, exp_vec());
            end
            if (p == 0 && j == 1) begin
               n_checks++;
               if (gio !== 1'b1 || gcpu !== 1'b0) begin
                  n_fail++;
                  $display("FAIL steal_first: got gio=%b gcpu=%b expected 1 0", gio, gcpu);
               end
            end
            if (p == 0 && j == 11) begin
               n_checks++;
               if (id !== 1'b1 || gcpu !== 1'b1 || gio !== 1'b0 || ab !== 1'b0) begin
                  n_fail++;
                  $display("FAIL steal_handover: got id=%b gcpu=%b gio=%b ab=%b expected 1 1 0 0",
                           id, gcpu, gio, ab);
               end
            end
         end
      end
      n_checks++;
      if (ab !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL steal_end: got ab=%b busy=%b expected 1 0", ab, busy);
      end
`else
      for (int k = 0; k < 30; k++) begin
         drive_step((k % 2) == 0, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if (obs !== exp_vec() || gio !== 1'b0 || id !== 1'b0) begin
            n_fail++;
            $display("FAIL io_ignored k=%0d: got %h expected %h", k, obs, exp_vec());
         end
      end
`endif
   endtask

   task automatic test_stop();
      int dones = 0;
      do_reset();
      for (int j = 1; j <= 20; j++) begin
         for (int p = 0; p < 2; p++) begin
            drive_step(p == 0, 1'b1, 1'b0, j >= 5);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL stop j=%0d p=%0d: got %h expected %h", j, p, obs, exp_vec());
            end
            dones += int'(cd);
         end
      end
      n_checks++;
      if (dones != 1 || gcpu !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_idle: got dones=%0d gcpu=%b busy=%b expected 1 0 0",
                  dones, gcpu, busy);
      end
      drive_step(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec() || gcpu !== 1'b1 || ring !== 10'd1) begin
         n_fail++;
         $display("FAIL stop_release: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int j = 1; j <= 7; j++) begin
         drive_step(1'b1, 1'b1, 1'b0, 1'b0);
         drive_step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      n_checks++;
      if (ring !== 10'h040 || wd !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_at_c7: got ring=%h wd=%b expected 040 1", ring, wd);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL mid_async_reset: got %h expected 0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_step(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec() || ring !== 10'd1 || gcpu !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_restart: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      bit c = 0, i = 0, s = 0;
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 15) == 0) c = ~c;
         if ($urandom_range(0, 19) == 0) i = ~i;
         if ($urandom_range(0, 29) == 0) s = ~s;
         drive_step($urandom_range(0, 2) == 0, c, i, s);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL random k=%0d: got %h expected %h", k, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_cpu();
      test_back_to_back();
      test_cycle_steal();
      test_stop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
